// File: rtl/fft_frame_source.sv
// Frames a free-running audio sample stream into FFT_SIZE-beat AXI-stream frames with a small FWFT buffer.
// Optional pattern generator (counter ramp) guarded by FFT_FRAME_SOURCE_TEST_PATTERN_EN.
`ifndef AXI_WIDTH
`define AXI_WIDTH (2*SAMPLE_WIDTH)
`endif
`ifndef BYTE_COUNT
`define BYTE_COUNT ((2*SAMPLE_WIDTH+7)/8)
`endif

module fft_frame_source #(
    parameter int FFT_SIZE     = 4096,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    input  logic                    frame_go,
    output logic                    frame_busy,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    overflow,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [`AXI_WIDTH-1:0]   m_axis_tdata,
    output logic [`BYTE_COUNT-1:0]  m_axis_tkeep
);

    localparam int CW = $clog2(FFT_SIZE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FFT_SIZE - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
    logic                    ovf_q, ovf_d;
    logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                    streaming, fifo_empty, fifo_full;
    logic                    wr_en, drop, pop, beat, last_beat;
    logic [SAMPLE_WIDTH-1:0] head;

`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
    logic pat_q, pat_d;
`endif

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head       = mem[rd_q[AW-1:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        ovf_d     = ovf_q;
        streaming = (state_q == S_STREAM);
`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
        pat_d         = pat_q;
        m_axis_tvalid = streaming && (pat_q || !fifo_empty);
        wr_en         = streaming && !pat_q && sample_valid && !fifo_full;
        drop          = streaming && !pat_q && sample_valid && fifo_full;
        beat          = m_axis_tvalid && m_axis_tready;
        pop           = beat && !pat_q;
        m_axis_tdata  = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata[SAMPLE_WIDTH-1:0] = pat_q ? SAMPLE_WIDTH'(cnt_q) : head;
        end
`else
        m_axis_tvalid = streaming && !fifo_empty;
        wr_en         = streaming && sample_valid && !fifo_full;
        drop          = streaming && sample_valid && fifo_full;
        beat          = m_axis_tvalid && m_axis_tready;
        pop           = beat;
        m_axis_tdata  = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata[SAMPLE_WIDTH-1:0] = head;
        end
`endif
        last_beat    = beat && (cnt_q == CNT_LAST);
        m_axis_tlast = m_axis_tvalid && (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
                    pat_d   = test_mode;
`endif
                end
            end
            S_STREAM: begin
                if (wr_en) wr_d = wr_q + PTR_ONE;
                if (pop)   rd_d = rd_q + PTR_ONE;
                if (drop)  ovf_d = 1'b1;
                if (beat)  cnt_d = cnt_q + CNT_ONE;
                // Frame complete: anything still buffered belongs to no frame.
                if (last_beat) begin
                    state_d = S_IDLE;
                    wr_d    = '0;
                    rd_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
            pat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
`ifdef FFT_FRAME_SOURCE_TEST_PATTERN_EN
            pat_q   <= pat_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q[AW-1:0]] <= sample_data;
        end
    end

    assign frame_busy   = (state_q == S_STREAM);
    assign overflow     = ovf_q;
    assign m_axis_tkeep = '1;

endmodule
